// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: bus widths, write-back source
// encodings and the stage's run/drain/halt state encoding.
package mem_stage_pkg;

    localparam int XLEN_DEFAULT     = 32;
    localparam int PC_WIDTH_DEFAULT = 32;
    localparam int REG_ADDR_W       = 5;
    localparam int WB_SEL_W         = 2;

    // {pc, exe_result, rf_wr_sel, rf_wr_en, reg_waddr, mem_rdata, inst_ebreak}
    function automatic int exe_to_mem_w(input int xlen, input int pcw);
        return pcw + xlen + WB_SEL_W + 1 + REG_ADDR_W + xlen + 1;
    endfunction

    // {pc, wb_data, rf_wr_en, reg_waddr, inst_ebreak}
    function automatic int mem_to_wb_w(input int xlen, input int pcw);
        return pcw + xlen + 1 + REG_ADDR_W + 1;
    endfunction

    // {rf_wr_en & mem_valid, reg_waddr, wb_data}
    function automatic int bypass_w(input int xlen);
        return 1 + REG_ADDR_W + xlen;
    endfunction

    localparam int EXE_TO_MEM_BUS_WIDTH = exe_to_mem_w(XLEN_DEFAULT, PC_WIDTH_DEFAULT);
    localparam int MEM_TO_WB_BUS_WIDTH  = mem_to_wb_w(XLEN_DEFAULT, PC_WIDTH_DEFAULT);
    localparam int BYPASS_BUS_WIDTH     = bypass_w(XLEN_DEFAULT);

    // Write-back data source select
    localparam logic [WB_SEL_W-1:0] WB_SEL_EXE  = 2'b00;
    localparam logic [WB_SEL_W-1:0] WB_SEL_MEM  = 2'b01;
    localparam logic [WB_SEL_W-1:0] WB_SEL_LINK = 2'b10;
    localparam logic [WB_SEL_W-1:0] WB_SEL_ZERO = 2'b11;

    // RUN: normal flow. DRAIN: ebreak held in the stage, intake closed.
    // HALT: ebreak retired, stage frozen until reset.
    typedef enum logic [1:0] {
        MEM_RUN   = 2'd0,
        MEM_DRAIN = 2'd1,
        MEM_HALT  = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_stage_perf_counters.sv
// Free-running cycle counter and retired-instruction counter, both 64 bits
// and wrapping naturally.
module perf_counters (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cycle_en,
    input  logic        retire_en,
    output logic [63:0] cycle_cnt,
    output logic [63:0] retired_cnt
);

    // Cycle counter advances on every enabled cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cycle_cnt <= '0;
        else if (cycle_en) cycle_cnt <= cycle_cnt + 64'd1;
    end

    // Retired counter advances on each instruction handed downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) retired_cnt <= '0;
        else if (retire_en) retired_cnt <= retired_cnt + 64'd1;
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: one register slot between execute and write-back.
// Selects write-back data, exposes a bypass path to decode, and stops the
// core once an ebreak has drained through to write-back.
//
// Handshake: an instruction moves into this stage on a cycle where
// exe_to_mem_valid && mem_allow_in, and leaves on a cycle where
// mem_to_wb_valid && wb_allow_in. While mem_to_wb_valid is high and
// wb_allow_in is low the outgoing bus is held stable. Both may happen in one
// cycle, replacing the slot contents without a bubble.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int PC_WIDTH = PC_WIDTH_DEFAULT,
    localparam int E2M_W   = exe_to_mem_w(XLEN, PC_WIDTH),
    localparam int M2W_W   = mem_to_wb_w(XLEN, PC_WIDTH),
    localparam int BYP_W   = bypass_w(XLEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             exe_to_mem_valid,
    input  logic [E2M_W-1:0] exe_to_mem_bus,
    output logic             mem_allow_in,
    input  logic             wb_allow_in,
    output logic             mem_to_wb_valid,
    output logic [M2W_W-1:0] mem_to_wb_bus,
    output logic [BYP_W-1:0] mem_to_id_bypass_bus,
    output logic             mem_valid,
    output logic             cpu_halted,
    output logic [63:0]      retired_cnt,
    output logic [63:0]      cycle_cnt
);

    typedef struct packed {
        logic [PC_WIDTH-1:0]   pc;
        logic [XLEN-1:0]       exe_result;
        logic [WB_SEL_W-1:0]   rf_wr_sel;
        logic                  rf_wr_en;
        logic [REG_ADDR_W-1:0] reg_waddr;
        logic [XLEN-1:0]       mem_rdata;
        logic                  inst_ebreak;
    } exe_to_mem_t;

    exe_to_mem_t         in_fields;
    exe_to_mem_t         mem_r;
    mem_state_e          state_q;
    mem_state_e          state_d;
    logic                stage_open;
    logic                count_cycle;
    logic                accept;
    logic                handoff;
    logic [PC_WIDTH-1:0] pc_plus4;
    logic [XLEN-1:0]     wb_data;
    logic                wb_we;

    assign in_fields = exe_to_mem_bus;

    // mem_ready_go is constant 1, so occupancy alone gates intake
    assign mem_allow_in    = stage_open && (!mem_valid || wb_allow_in);
    assign accept          = exe_to_mem_valid && mem_allow_in;
    assign mem_to_wb_valid = mem_valid;
    assign handoff         = mem_to_wb_valid && wb_allow_in;

    // Occupancy flag: refill on intake, empty on handoff, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mem_valid <= 1'b0;
        else if (mem_allow_in) mem_valid <= exe_to_mem_valid;
        else if (handoff) mem_valid <= 1'b0;
    end

    // Data slot: contents are don't-care while empty, so no reset
    always_ff @(posedge clk) begin
        if (accept) mem_r <= in_fields;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= MEM_RUN;
        else state_q <= state_d;
    end

    // FSM next state: ebreak closes intake, its handoff halts the core
    always_comb begin
        state_d = state_q;
        case (state_q)
            MEM_RUN:   if (accept && in_fields.inst_ebreak) state_d = MEM_DRAIN;
            MEM_DRAIN: if (handoff) state_d = MEM_HALT;
            MEM_HALT:  state_d = MEM_HALT;
            default:   state_d = MEM_RUN;
        endcase
    end

    // FSM outputs: intake only in RUN, cycle counting stops in HALT
    always_comb begin
        stage_open  = (state_q == MEM_RUN);
        cpu_halted  = (state_q == MEM_HALT);
        count_cycle = (state_q != MEM_HALT);
    end

    assign pc_plus4 = mem_r.pc + PC_WIDTH'(4);

    // Write-back data source mux
    always_comb begin
        wb_data = '0;
        case (mem_r.rf_wr_sel)
            WB_SEL_EXE:  wb_data = mem_r.exe_result;
            WB_SEL_MEM:  wb_data = mem_r.mem_rdata;
            WB_SEL_LINK: wb_data = XLEN'(pc_plus4);
            WB_SEL_ZERO: wb_data = '0;
            default:     wb_data = '0;
        endcase
    end

    // x0 is hardwired zero, so a write to it is dropped here
    assign wb_we = mem_r.rf_wr_en && (mem_r.reg_waddr != '0);

    assign mem_to_wb_bus        = {mem_r.pc, wb_data, wb_we, mem_r.reg_waddr, mem_r.inst_ebreak};
    assign mem_to_id_bypass_bus = {wb_we & mem_valid, mem_r.reg_waddr, wb_data};

    perf_counters u_perf_counters (
        .clk         (clk),
        .rst_n       (rst_n),
        .cycle_en    (count_cycle),
        .retire_en   (handoff),
        .cycle_cnt   (cycle_cnt),
        .retired_cnt (retired_cnt)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a small reference model predicts intake,
// handoff, FSM state and counters; expected write-back buses are queued at
// intake and compared while the stage holds them.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int E2M_W = EXE_TO_MEM_BUS_WIDTH;
    localparam int M2W_W = MEM_TO_WB_BUS_WIDTH;
    localparam int BYP_W = BYPASS_BUS_WIDTH;
    localparam int S_RUN   = 0;
    localparam int S_DRAIN = 1;
    localparam int S_HALT  = 2;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             exe_to_mem_valid = 1'b0;
    logic [E2M_W-1:0] exe_to_mem_bus = '0;
    logic             wb_allow_in = 1'b0;
    logic             mem_allow_in;
    logic             mem_to_wb_valid;
    logic [M2W_W-1:0] mem_to_wb_bus;
    logic [BYP_W-1:0] mem_to_id_bypass_bus;
    logic             mem_valid;
    logic             cpu_halted;
    logic [63:0]      retired_cnt;
    logic [63:0]      cycle_cnt;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .exe_to_mem_valid     (exe_to_mem_valid),
        .exe_to_mem_bus       (exe_to_mem_bus),
        .mem_allow_in         (mem_allow_in),
        .wb_allow_in          (wb_allow_in),
        .mem_to_wb_valid      (mem_to_wb_valid),
        .mem_to_wb_bus        (mem_to_wb_bus),
        .mem_to_id_bypass_bus (mem_to_id_bypass_bus),
        .mem_valid            (mem_valid),
        .cpu_halted           (cpu_halted),
        .retired_cnt          (retired_cnt),
        .cycle_cnt            (cycle_cnt)
    );

    // ---------------- scoreboard / model ----------------
    int               vectors = 0;
    int               miscompares = 0;
    logic [M2W_W-1:0] exp_q[$];
    logic             m_valid = 1'b0;
    int               m_state = S_RUN;
    logic [63:0]      m_retired = '0;
    logic [63:0]      m_cycles = '0;
    logic [E2M_W-1:0] cur_bus;
    logic [M2W_W-1:0] cur_exp;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Build an incoming bus and its expected write-back bus from fields
    task automatic make_op(input logic [31:0] pc, input logic [31:0] exe, input logic [1:0] sel,
                           input logic we, input logic [4:0] waddr, input logic [31:0] rdata,
                           input logic eb);
        logic [31:0] d;
        case (sel)
            2'b00:   d = exe;
            2'b01:   d = rdata;
            2'b10:   d = pc + 32'd4;
            default: d = 32'd0;
        endcase
        cur_bus = {pc, exe, sel, we, waddr, rdata, eb};
        cur_exp = {pc, d, (we && (waddr != 5'd0)), waddr, eb};
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge; checks outputs, advances model over the next rising edge
    task automatic cycle(input logic v, input logic wb);
        logic             exp_allow;
        logic             acc;
        logic             hand;
        logic [M2W_W-1:0] head;
        exe_to_mem_valid = v;
        exe_to_mem_bus   = cur_bus;
        wb_allow_in      = wb;
        #1;
        exp_allow = (m_state == S_RUN) && (!m_valid || wb);
        check("allow_in", mem_allow_in, exp_allow);
        check("mem_valid", mem_valid, m_valid);
        check("wb_valid", mem_to_wb_valid, m_valid);
        check("halted", cpu_halted, m_state == S_HALT);
        check("retired", retired_cnt, m_retired);
        check("cycles", cycle_cnt, m_cycles);
        if (m_valid && exp_q.size() > 0) begin
            head = exp_q[0];
            check("wb_bus", mem_to_wb_bus, head);
            check("bypass", mem_to_id_bypass_bus, {head[6], head[5:1], head[38:7]});
        end
        acc  = v && exp_allow;
        hand = m_valid && wb;
        if (m_state != S_HALT) m_cycles++;
        if (hand) begin
            if (exp_q.size() > 0) head = exp_q.pop_front();
            m_retired++;
        end
        if (acc) exp_q.push_back(cur_exp);
        if (exp_allow) m_valid = v;
        else if (hand) m_valid = 1'b0;
        if (m_state == S_RUN && acc && cur_bus[0]) m_state = S_DRAIN;
        else if (m_state == S_DRAIN && hand) m_state = S_HALT;
        @(negedge clk);
    endtask

    task automatic model_clear();
        m_valid = 1'b0;
        m_state = S_RUN;
        m_retired = '0;
        m_cycles = '0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exe_to_mem_valid = 1'b0;
        wb_allow_in = 1'b0;
        #1;
        check("rst_valid", mem_valid, 1'b0);
        check("rst_halted", cpu_halted, 1'b0);
        check("rst_retired", retired_cnt, 64'd0);
        check("rst_cycles", cycle_cnt, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    // Assert reset between edges and check it takes effect before the next edge
    task automatic reset_mid_cycle();
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", mem_valid, 1'b0);
        check("arst_halted", cpu_halted, 1'b0);
        check("arst_retired", retired_cnt, 64'd0);
        check("arst_cycles", cycle_cnt, 64'd0);
        check("arst_allow", mem_allow_in, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        @(negedge clk);
        do_reset();

        // ALU, load, JAL to x0, zero select, link wrap-around
        make_op(32'h8000_0000, 32'h0000_1234, 2'b00, 1'b1, 5'd5, 32'h0, 1'b0);
        cycle(1'b1, 1'b1);
        make_op(32'h8000_0004, 32'h0, 2'b01, 1'b1, 5'd7, 32'hFFFF_FF80, 1'b0);
        cycle(1'b1, 1'b1);
        make_op(32'h8000_0010, 32'h5555_5555, 2'b10, 1'b1, 5'd0, 32'h0, 1'b0);
        cycle(1'b1, 1'b1);
        make_op(32'h8000_0014, 32'hDEAD_BEEF, 2'b11, 1'b1, 5'd9, 32'hCAFE_F00D, 1'b0);
        cycle(1'b1, 1'b1);
        make_op(32'hFFFF_FFFC, 32'h0, 2'b10, 1'b1, 5'd1, 32'h0, 1'b0);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);

        // Back-pressure: slot full, downstream stalled for 3 cycles, then release
        make_op(32'h8000_0100, 32'hA5A5_0001, 2'b00, 1'b1, 5'd3, 32'h0, 1'b0);
        cycle(1'b1, 1'b1);
        make_op(32'h8000_0104, 32'hA5A5_0002, 2'b00, 1'b1, 5'd4, 32'h0, 1'b0);
        repeat (3) cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);

        // Random traffic with random downstream stalls, no ebreak
        for (int i = 0; i < 60; i++) begin
            make_op($urandom(), $urandom(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 31)), $urandom(), 1'b0);
            cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        end
        cycle(1'b0, 1'b1);

        // Ebreak: held under back-pressure, intake closed, then halt and freeze
        make_op(32'h8000_0200, 32'h0, 2'b00, 1'b0, 5'd0, 32'h0, 1'b1);
        cycle(1'b1, 1'b1);
        make_op(32'h8000_0204, 32'h1111_1111, 2'b00, 1'b1, 5'd6, 32'h0, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'($urandom_range(0, 1)));

        // Reset mid-DRAIN between edges, then normal operation resumes
        do_reset();
        make_op(32'h8000_0300, 32'h0, 2'b00, 1'b0, 5'd0, 32'h0, 1'b1);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        reset_mid_cycle();
        make_op(32'h8000_0000, 32'h0000_1234, 2'b00, 1'b1, 5'd5, 32'h0, 1'b0);
        cycle(1'b1, 1'b1);
        make_op(32'h8000_0004, 32'h0, 2'b01, 1'b1, 5'd8, 32'h0000_0077, 1'b0);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
